// File: rtl/edge_event_arbiter_if.sv
// Shared event port between the edge arbiter and its consumer.
// Master offers channel/kind with valid; slave answers with ready.
interface edge_event_arbiter_if #(
  parameter int CH_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_fall;

  modport master (
    output evt_valid,
    output evt_ch,
    output evt_fall,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_ch,
    input  evt_fall,
    output evt_ready
  );
endinterface

// File: rtl/edge_event_arbiter.sv
// Per-channel edge capture with round-robin grant onto one event port.
// EDGE_ARB_FALL_EN: also report falling edges (evt_fall=1).
module edge_event_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       sig_in,
  output logic [N_CH-1:0]       pending,
  output logic [N_CH-1:0]       ovf,
  input  logic                  ovf_clr,
  edge_event_arbiter_if.master  evt
);

  typedef enum logic {
    S_IDLE,
    S_OFFER
  } state_e;

  state_e          st_q, st_d;
  logic [N_CH-1:0] prev_q;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic [N_CH-1:0] rise, edge_v, hs_vec;
  logic [CH_W-1:0] rr_q, rr_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [CH_W-1:0] sel, cand;
  logic            found, hs;
  int              idx;
`ifdef EDGE_ARB_FALL_EN
  logic [N_CH-1:0] fall, kind_q, kind_d;
  logic            fall_q, fall_d;
`endif

  always_comb begin
    rise = sig_in & ~prev_q;
`ifdef EDGE_ARB_FALL_EN
    fall   = ~sig_in & prev_q;
    edge_v = rise | fall;
`else
    edge_v = rise;
`endif
    hs     = (st_q == S_OFFER) && evt.evt_ready;
    hs_vec = hs ? (N_CH'(1) << ch_q) : '0;
    // A channel being handshaken this cycle is free to take a new edge.
    pend_d = (pend_q & ~hs_vec) | edge_v;
    ovf_d  = (ovf_clr ? '0 : ovf_q) | (edge_v & pend_q & ~hs_vec);
`ifdef EDGE_ARB_FALL_EN
    kind_d = kind_q;
    for (int i = 0; i < N_CH; i++) begin
      if (edge_v[i] && !(pend_q[i] && !hs_vec[i]))
        kind_d[i] = fall[i];
    end
`endif

    // First pending channel strictly after rr_q, cyclically.
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    idx   = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx  = (int'(rr_q) + k) % N_CH;
      cand = CH_W'(idx);
      if (!found && pend_q[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end

    st_d = st_q;
    rr_d = rr_q;
    ch_d = ch_q;
`ifdef EDGE_ARB_FALL_EN
    fall_d = fall_q;
`endif
    unique case (st_q)
      S_IDLE: begin
        if (found) begin
          st_d = S_OFFER;
          ch_d = sel;
`ifdef EDGE_ARB_FALL_EN
          fall_d = kind_q[sel];
`endif
        end
      end
      S_OFFER: begin
        if (evt.evt_ready) begin
          st_d = S_IDLE;
          rr_d = ch_q;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= S_IDLE;
      prev_q <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
      rr_q   <= CH_W'(N_CH - 1);
      ch_q   <= '0;
`ifdef EDGE_ARB_FALL_EN
      kind_q <= '0;
      fall_q <= 1'b0;
`endif
    end else begin
      st_q   <= st_d;
      prev_q <= sig_in;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      rr_q   <= rr_d;
      ch_q   <= ch_d;
`ifdef EDGE_ARB_FALL_EN
      kind_q <= kind_d;
      fall_q <= fall_d;
`endif
    end
  end

  assign evt.evt_valid = (st_q == S_OFFER);
  assign evt.evt_ch    = ch_q;
`ifdef EDGE_ARB_FALL_EN
  assign evt.evt_fall  = fall_q;
`else
  assign evt.evt_fall  = 1'b0;
`endif
  assign pending = pend_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter.
// Model pushes expected grants; a negedge monitor pops on handshakes.
module tb_edge_event_arbiter;
  localparam int N = 4;
  localparam int W = 2;
`ifdef EDGE_ARB_FALL_EN
  localparam bit FALL_EN = 1'b1;
`else
  localparam bit FALL_EN = 1'b0;
`endif

  typedef struct {
    int ch;
    bit fall;
  } ev_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] sig_in = '0;
  logic         ovf_clr = 1'b0;
  logic [N-1:0] pending;
  logic [N-1:0] ovf;

  edge_event_arbiter_if #(.CH_W(W)) bus ();

  edge_event_arbiter #(.N_CH(N), .CH_W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .sig_in  (sig_in),
    .pending (pending),
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
    .evt     (bus)
  );

  always #5 clk = ~clk;

  int  errs = 0;
  int  checks = 0;
  ev_t sb[$];

  bit m_prev[N];
  bit m_pend[N];
  bit m_kind[N];
  bit m_ovf[N];
  bit m_off;
  int m_rr;
  int m_ch;
  bit m_fall;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pack(bit a[N]);
    int v = 0;
    for (int i = 0; i < N; i++) if (a[i]) v |= (1 << i);
    return v;
  endfunction

  // Spec rules applied to the inputs seen at this clock edge.
  task automatic model_step();
    bit np[N];
    bit nk[N];
    bit no[N];
    bit hs;
    bit busy;
    bit r, f, e;
    int first;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_prev[i] = 0; m_pend[i] = 0; m_kind[i] = 0; m_ovf[i] = 0;
      end
      m_off = 0; m_rr = N - 1; m_ch = 0; m_fall = 0;
      return;
    end
    hs = m_off && bus.evt_ready;
    for (int i = 0; i < N; i++) begin
      r = sig_in[i] && !m_prev[i];
      f = FALL_EN && !sig_in[i] && m_prev[i];
      e = r || f;
      busy = m_pend[i] && !(hs && m_ch == i);
      np[i] = busy || e;
      nk[i] = (e && !busy) ? f : m_kind[i];
      no[i] = (ovf_clr ? 1'b0 : m_ovf[i]) || (e && busy);
    end
    if (m_off) begin
      if (hs) begin
        m_off = 0;
        m_rr  = m_ch;
      end
    end else begin
      first = -1;
      for (int k = 1; k <= N; k++)
        if (first < 0 && m_pend[(m_rr + k) % N]) first = (m_rr + k) % N;
      if (first >= 0) begin
        m_off  = 1;
        m_ch   = first;
        m_fall = m_kind[first];
      end
    end
    for (int i = 0; i < N; i++) begin
      m_pend[i] = np[i]; m_kind[i] = nk[i]; m_ovf[i] = no[i];
      m_prev[i] = sig_in[i];
    end
  endtask

  task automatic cyc(logic [N-1:0] s, bit rdy, bit clr, bit rst);
    @(posedge clk);
    model_step();
    #1;
    check("pending", int'(pending), pack(m_pend));
    check("ovf", int'(ovf), pack(m_ovf));
    check("evt_valid", int'(bus.evt_valid), int'(m_off));
    sig_in        = s;
    bus.evt_ready = rdy;
    ovf_clr       = clr;
    reset         = rst;
    if (m_off && rdy && !rst) sb.push_back('{m_ch, m_fall});
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!reset && bus.evt_valid && bus.evt_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_event: got ch %0d expected none", bus.evt_ch);
      end else begin
        e = sb.pop_front();
        check("evt_ch", int'(bus.evt_ch), e.ch);
        check("evt_fall", int'(bus.evt_fall), int'(e.fall));
      end
    end
  end

  initial begin
    int     rp;
    logic [N-1:0] s;
    bus.evt_ready = 1'b0;
    cyc('0, 1, 0, 1);
    cyc('0, 1, 0, 1);
    cyc('0, 1, 0, 0);
    cyc('0, 1, 0, 0);
    // single rise on ch2
    cyc(4'b0100, 1, 0, 0);
    repeat (5) cyc('0, 1, 0, 0);
    // simultaneous rises on 0,1,3
    cyc(4'b1011, 1, 0, 0);
    repeat (9) cyc('0, 1, 0, 0);
    // overflow on ch1
    cyc(4'b0010, 0, 0, 0);
    cyc('0, 0, 0, 0);
    cyc(4'b0010, 0, 0, 0);
    repeat (3) cyc('0, 0, 0, 0);
    repeat (4) cyc('0, 1, 0, 0);
    cyc('0, 1, 1, 0);
    repeat (2) cyc('0, 1, 0, 0);
    // new ch2 edge in its handshake cycle
    cyc(4'b0100, 0, 0, 0);
    repeat (3) cyc('0, 0, 0, 0);
    cyc(4'b0100, 1, 0, 0);
    repeat (6) cyc('0, 1, 0, 0);
    // reset while offering with ch0 held high
    repeat (4) cyc(4'b0001, 0, 0, 0);
    cyc(4'b0001, 0, 0, 1);
    repeat (6) cyc(4'b0001, 1, 0, 0);
    // ch1 high then low
    repeat (4) cyc(4'b0011, 1, 0, 0);
    repeat (6) cyc(4'b0001, 1, 0, 0);
    // randomized phases with varying consumer readiness
    s = 4'b0001;
    for (int ph = 0; ph < 12; ph++) begin
      rp = $urandom_range(10, 100);
      for (int c = 0; c < 250; c++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 5) == 0) s[i] = ~s[i];
        cyc(s, $urandom_range(1, 100) <= rp,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 199) == 0);
      end
    end
    repeat (20) cyc(s, 1, 0, 0);
    @(posedge clk);
    #2;
    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
